// File: rtl/mov_mux_pipe.sv
// Two-stage elastic N:1 channel mux for the PIM mov datapath.
// Stage 1 pre-selects within groups of four channels; stage 2 picks the group.
`timescale 1ns/1ps
module mov_mux_pipe_chk #(
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
) ();
  generate
    if ((NUM_IN < 2) || (NUM_IN > 64) || ((1 << SEL_W) < NUM_IN)) begin : g_bad_params
      $fatal(1, "mov_mux_pipe: NUM_IN must be 2..64 and 2**SEL_W >= NUM_IN");
    end
  endgenerate
endmodule

module mov_mux_pipe #(
  parameter int NUM_IN = 16,
  parameter int DATA_W = 10,
  parameter int SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_err,
  output logic                     busy
);
  localparam int G    = (NUM_IN + 3) / 4;
  localparam int SX_W = (SEL_W < 2) ? 2 : SEL_W;

  logic [G*4*DATA_W-1:0] pad_data;
  logic [SX_W-1:0]       sel_x;
  logic                  in_err;
  logic [DATA_W-1:0]     grp_next [G];
  logic [DATA_W-1:0]     s1_grp   [G];
  logic [SX_W-1:0]       s1_gidx;
  logic                  s1_err;
  logic                  s1_v;
  logic                  s2_v;
  logic                  s1_en;
  logic                  s2_en;
  logic [DATA_W-1:0]     s2_data_next;

  mov_mux_pipe_chk #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_chk ();

  // Missing members of the last group read as zero through the padding.
  assign pad_data = (G*4*DATA_W)'(in_data);
  assign sel_x    = SX_W'(in_sel);
  assign in_err   = (32'(in_sel) >= 32'(NUM_IN));

  assign s2_en     = s1_v & (~s2_v | out_ready);
  assign in_ready  = ~s1_v | s2_en;
  assign s1_en     = in_valid & in_ready;
  assign out_valid = s2_v;
  assign busy      = s1_v | s2_v;

  // Per-group lane select by the low two select bits.
  always_comb begin
    for (int g = 0; g < G; g++) begin
      grp_next[g] = '0;
      case (sel_x[1:0])
        2'd0:    grp_next[g] = pad_data[(4*g + 0)*DATA_W +: DATA_W];
        2'd1:    grp_next[g] = pad_data[(4*g + 1)*DATA_W +: DATA_W];
        2'd2:    grp_next[g] = pad_data[(4*g + 2)*DATA_W +: DATA_W];
        2'd3:    grp_next[g] = pad_data[(4*g + 3)*DATA_W +: DATA_W];
        default: grp_next[g] = '0;
      endcase
    end
  end

  // Group select; a group index past the last group yields zero.
  always_comb begin
    s2_data_next = '0;
    for (int g = 0; g < G; g++) begin
      s2_data_next = s2_data_next | ((s1_gidx == SX_W'(g)) ? s1_grp[g] : '0);
    end
    if (s1_err) begin
      s2_data_next = '0;
    end else begin
      s2_data_next = s2_data_next;
    end
  end

  // Stage valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_v <= 1'b1;
      end else if (s2_en) begin
        s1_v <= 1'b0;
      end else begin
        s1_v <= s1_v;
      end
      if (s2_en) begin
        s2_v <= 1'b1;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end else begin
        s2_v <= s2_v;
      end
    end
  end

  // Stage 1 capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < G; g++) begin
        s1_grp[g] <= '0;
      end
      s1_gidx <= '0;
      s1_err  <= 1'b0;
    end else if (s1_en) begin
      for (int g = 0; g < G; g++) begin
        s1_grp[g] <= grp_next[g];
      end
      s1_gidx <= sel_x >> 2'd2;
      s1_err  <= in_err;
    end else begin
      s1_gidx <= s1_gidx;
      s1_err  <= s1_err;
    end
  end

  // Stage 2 output registers; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (s2_en) begin
      out_data <= s2_data_next;
      out_err  <= s1_err;
    end else begin
      out_data <= out_data;
      out_err  <= out_err;
    end
  end
endmodule

// File: tb/tb_mov_mux_pipe.sv
// Scoreboard bench for mov_mux_pipe: a 16-channel and a 10-channel instance,
// directed vectors plus a short random-handshake phase.
`timescale 1ns/1ps
module tb_mov_mux_pipe;
  localparam int W  = 10;
  localparam int NA = 16;
  localparam int NB = 10;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err, a_busy;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_busy;
  logic [NA*W-1:0] a_in_data;
  logic [NB*W-1:0] b_in_data;
  logic [3:0] a_in_sel, b_in_sel;
  logic [W-1:0] a_out_data, b_out_data;

  exp_t q_a[$];
  exp_t q_b[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mov_mux_pipe #(.NUM_IN(NA), .DATA_W(W), .SEL_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sel(a_in_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err), .busy(a_busy));

  mov_mux_pipe #(.NUM_IN(NB), .DATA_W(W), .SEL_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err), .busy(b_busy));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [NA*W-1:0] d, input int sel, input int n, input bit lat);
    exp_t e;
    e.err  = (sel >= n);
    e.data = e.err ? 32'd0 : 32'(d[sel*W +: W]);
    e.acc  = cyc;
    e.lat  = lat;
    return e;
  endfunction

  task automatic send_a(input int sel, input bit lat, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    while (!done) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_sel = 4'(sel);
      #4;
      if (a_in_ready) begin
        q_a.push_back(mk(a_in_data, sel, NA, lat));
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 50) begin
          tests++; fails++;
          $display("FAIL a_accept_timeout: got no in_ready after %0d cycles, expected acceptance", stalls);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_b(input int sel, input bit lat, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    while (!done) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_sel = 4'(sel);
      #4;
      if (b_in_ready) begin
        q_b.push_back(mk((NA*W)'(b_in_data), sel, NB, lat));
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 50) begin
          tests++; fails++;
          $display("FAIL b_accept_timeout: got no in_ready after %0d cycles, expected acceptance", stalls);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor for instance A: pops and compares each delivered beat.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
        if (q_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_extra_beat: got data 0x%0h, expected no beat", a_out_data);
        end else begin
          e = q_a.pop_front();
          check("a_data", 32'(a_out_data), e.data);
          check("a_err", 32'(a_out_err), 32'(e.err));
          if (e.lat) check("a_latency", 32'(cyc - e.acc), 32'd2);
        end
      end
    end
  end

  // Monitor for instance B.
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
        if (q_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_extra_beat: got data 0x%0h, expected no beat", b_out_data);
        end else begin
          e = q_b.pop_front();
          check("b_data", 32'(b_out_data), e.data);
          check("b_err", 32'(b_out_err), 32'(e.err));
          if (e.lat) check("b_latency", 32'(cyc - e.acc), 32'd2);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : drv
    int st, tot, acc, idx, frz_bad, frz_seen, gaps, bcnt, n;
    int bp_sel [6] = '{2, 4, 6, 8, 10, 12};
    int b_sel [8] = '{12, 9, 10, 11, 8, 15, 0, 13};

    rst_n = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_in_sel = 4'd0; b_in_sel = 4'd0;
    for (int k = 0; k < NA; k++) a_in_data[k*W +: W] = W'(k * 3);
    for (int k = 0; k < NB; k++) b_in_data[k*W +: W] = W'(k * 37 + 5);
    b_in_data[9*W +: W] = 10'h2AA;

    repeat (3) @(negedge clk);
    #4;
    check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_out_data", 32'(a_out_data), 32'd0);
    check("rst_a_out_err", 32'(a_out_err), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    check("a_ready_after_reset", 32'(a_in_ready), 32'd1);

    // Single beat: channel 9 carries 27.
    send_a(9, 1'b1, st);
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      #4;
      bcnt += int'(a_busy);
    end
    check("a_busy_cycles", 32'(bcnt), 32'd2);

    // Back-to-back stream of all channels.
    tot = 0;
    for (int s = 0; s < 16; s++) begin
      send_a(s, 1'b1, st);
      tot += st;
    end
    check("a_stream_stalls", 32'(tot), 32'd0);
    idle(4);

    // Backpressure: five stalled cycles, then release.
    idx = 0; acc = 0; frz_bad = 0; frz_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_out_ready = 1'b0;
      a_in_valid = 1'b1;
      a_in_sel = 4'(bp_sel[idx]);
      #4;
      if (a_out_valid) begin
        frz_seen++;
        if (a_out_data !== 10'd6 || a_out_err !== 1'b0) frz_bad++;
      end
      if (a_in_ready) begin
        q_a.push_back(mk(a_in_data, bp_sel[idx], NA, 1'b0));
        idx++; acc++;
      end
    end
    check("a_bp_accepted", 32'(acc), 32'd2);
    check("a_bp_in_ready_low", 32'(a_in_ready), 32'd0);
    check("a_bp_frozen_seen", 32'(frz_seen), 32'd3);
    check("a_bp_frozen_bad", 32'(frz_bad), 32'd0);
    gaps = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_out_ready = 1'b1;
      if (idx < 6) begin
        a_in_valid = 1'b1;
        a_in_sel = 4'(bp_sel[idx]);
      end else begin
        a_in_valid = 1'b0;
      end
      #4;
      if (a_in_valid && a_in_ready) begin
        q_a.push_back(mk(a_in_data, bp_sel[idx], NA, 1'b0));
        idx++;
      end
      gaps += int'(!a_out_valid);
    end
    check("a_bp_release_gaps", 32'(gaps), 32'd0);
    check("a_bp_all_sent", 32'(idx), 32'd6);
    idle(4);

    // Asynchronous reset with two beats in flight.
    send_a(5, 1'b0, st);
    send_a(7, 1'b0, st);
    @(posedge clk); #2;
    rst_n = 1'b0;
    a_in_valid = 1'b0;
    #1;
    check("arst_out_valid", 32'(a_out_valid), 32'd0);
    check("arst_out_data", 32'(a_out_data), 32'd0);
    check("arst_busy", 32'(a_busy), 32'd0);
    q_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_a(11, 1'b1, st);
    idle(4);

    // Ten-channel instance: out-of-range selects and the padded last group.
    for (int i = 0; i < 8; i++) send_b(b_sel[i], 1'b1, st);
    idle(4);

    // Random handshakes on both instances with data changing every cycle.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < NA; k++) a_in_data[k*W +: W] = W'($urandom);
      for (int k = 0; k < NB; k++) b_in_data[k*W +: W] = W'($urandom);
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_in_sel    = 4'($urandom_range(0, 15));
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_in_sel    = 4'($urandom_range(0, 15));
      #4;
      if (a_in_valid && a_in_ready) q_a.push_back(mk(a_in_data, int'(a_in_sel), NA, 1'b0));
      if (b_in_valid && b_in_ready) q_b.push_back(mk((NA*W)'(b_in_data), int'(b_in_sel), NB, 1'b0));
    end
    @(negedge clk);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #4;
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    check("a_idle_busy", 32'(a_busy), 32'd0);
    check("b_idle_busy", 32'(b_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mov_mux_pipe.md
Name: mov_mux_pipe

Overview:
- Parametrised, pipelined N:1 data-move multiplexer for the PIM mov datapath; successor to the fixed 16-input combinational mov bus mux.
- Selects one of NUM_IN channels of DATA_W bits and delivers it through two registered stages.
- Elastic valid/ready handshake on both sides: one beat per cycle throughput, full backpressure.
- Flags out-of-range selects instead of aliasing them.

Parameters:
- NUM_IN, 16: number of input channels; legal range 2..64.
- DATA_W, 10: channel width in bits.
- SEL_W, 4: select width; must satisfy 2**SEL_W >= NUM_IN (elaboration-time assertion).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat offered.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  NUM_IN*DATA_W  flattened channels; channel k at bits [k*DATA_W +: DATA_W].
- in_sel  input  SEL_W  channel index for this beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  selected channel data.
- out_err  output  1  beat had in_sel >= NUM_IN; out_data is 0 for such a beat.
- busy  output  1  at least one beat is in flight (s1_v | s2_v).

Behaviour:
- Reset (async assert, sync deassert at the system level):
  - s1_v, s2_v, out_valid, out_err cleared; out_data = 0; all stage registers = 0.
  - in_ready = 1 while reset is held and immediately after.
- Stage 1, capture:
  - Channels are split into G = ceil(NUM_IN/4) groups of 4; missing members of the last group read as 0.
  - Each group is muxed by in_sel[1:0] into s1_grp[g].
  - Also registered: grp_idx = in_sel >> 2 and err = (in_sel >= NUM_IN).
  - Loads when in_valid & in_ready.
- Stage 2, output:
  - out_data <= err ? 0 : s1_grp[grp_idx]; out_err <= err.
  - For grp_idx >= G, data is 0 (err is already set).
- Advance rules:
  - s2_en = s1_v & (~s2_v | out_ready).
  - s1_en = in_valid & in_ready.
  - in_ready = ~s1_v | s2_en (combinational, no combinational path from in_valid).
  - s1_v next = s1_en ? 1 : (s2_en ? 0 : s1_v).
  - s2_v next = s2_en ? 1 : (out_ready ? 0 : s2_v).
  - out_valid = s2_v.
- Latency and throughput:
  - Minimum latency is 2 cycles: beat accepted at edge N appears with out_valid at edge N+2 (s1 at N+1, s2 at N+2).
  - Sustained throughput is 1 beat/cycle while out_ready = 1.
- Backpressure:
  - While out_valid & ~out_ready, out_data and out_err hold stable.
  - s1 may still fill once; then in_ready drops. No beat is lost or duplicated.
- Simultaneous events:
  - s2 drain and s1 reload in the same cycle: both happen; s1 passes its beat to s2 while capturing the new one.
  - Order of beats is preserved.
- Single-stage fill: a beat in s1 with s2 empty moves to s2 regardless of out_ready.
- Reset mid-operation: in-flight beats are discarded; no partial output.
- in_sel and in_data are sampled only on s1_en and may change freely otherwise.
- busy deasserts the cycle after the last beat leaves s2.

Test Plan:
- Default params, rst_n low then high; in_data channel k = k*3, in_sel = 9, out_ready = 1, one beat.
  -> out_valid exactly 2 cycles after acceptance, out_data = 27, out_err = 0, busy high for 2 cycles.
- Stream in_sel 0..15 back-to-back, out_ready = 1.
  -> in_ready constantly 1; outputs 0,3,...,45 in order on consecutive cycles.
- Hold out_ready = 0 for 5 cycles with a stream offered.
  -> exactly 2 beats accepted, then in_ready = 0; out_data frozen.
  -> On release, beats emerge in order with no gaps, drops or duplicates.
- NUM_IN = 10, SEL_W = 4, in_sel = 12.
  -> out_data = 0, out_err = 1.
  -> in_sel = 9 with channel 9 = 0x2AA gives out_data = 0x2AA, out_err = 0.
  -> Last group members 10 and 11 never leak.
- Assert rst_n low while 2 beats are in flight.
  -> out_valid = 0, out_data = 0, busy = 0 asynchronously.
  -> After release, the first new beat has 2-cycle latency and no stale data appears.
- Random valid/out_ready toggling, 10k beats, NUM_IN in {2, 7, 16, 64}, DATA_W in {1, 10, 32}.
  -> Scoreboard shows exact ordered match, out_err iff in_sel >= NUM_IN.
